// File: rtl/lms_input_aligner.sv
// Buffers u/d samples in two FIFOs and releases one aligned pair per fs_stb; outputs update the cycle after the strobe.
// Producers are throttled by per-FIFO ready (low only when full); an empty FIFO at a RUN strobe is an underrun, not a stall.
module lms_input_aligner #(
    parameter int SAMPLE_SIZE = 16,
    parameter int DEPTH       = 4,
    parameter int PRIME       = 2,
    parameter int CNT_SIZE    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fs_stb,
    input  logic                        u_valid,
    input  logic [SAMPLE_SIZE-1:0]      u_data,
    output logic                        u_ready,
    input  logic                        d_valid,
    input  logic [SAMPLE_SIZE-1:0]      d_data,
    output logic                        d_ready,
    output logic [SAMPLE_SIZE-1:0]      u_out,
    output logic [SAMPLE_SIZE-1:0]      d_out,
    output logic                        out_valid,
    output logic                        running,
    output logic                        underrun,
    output logic [CNT_SIZE-1:0]         underrun_cnt,
    output logic [$clog2(DEPTH):0]      u_level,
    output logic [$clog2(DEPTH):0]      d_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL  = LW'(DEPTH);
    localparam logic [LW-1:0] PRIME_LEVEL = LW'(PRIME);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;
    logic   pop;
    logic   underrun_evt;

    // Channel 0 carries u, channel 1 carries d; both pop together to keep pairs aligned.
    for (genvar ch = 0; ch < 2; ch++) begin : g_fifo
        logic [SAMPLE_SIZE-1:0] mem [DEPTH];
        logic [AW-1:0]          wr_ptr;
        logic [AW-1:0]          rd_ptr;
        logic [LW-1:0]          level;
        logic [SAMPLE_SIZE-1:0] wdata;
        logic [SAMPLE_SIZE-1:0] head;
        logic                   valid;
        logic                   ready;
        logic                   wr_en;

        assign wdata = (ch == 0) ? u_data : d_data;
        assign valid = (ch == 0) ? u_valid : d_valid;
        assign ready = (level != FULL_LEVEL);
        assign wr_en = valid && ready;
        assign head  = mem[rd_ptr];

        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[wr_ptr] <= wdata;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({wr_en, pop})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase
            end
        end
    end

    assign u_level = g_fifo[0].level;
    assign d_level = g_fifo[1].level;
    assign u_ready = g_fifo[0].ready;
    assign d_ready = g_fifo[1].ready;
    assign running = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Decisions use the registered levels, so a sample written this cycle is never popped this cycle.
    always_comb begin
        state_next   = state;
        pop          = 1'b0;
        underrun_evt = 1'b0;
        case (state)
            FILL: begin
                if ((u_level >= PRIME_LEVEL) && (d_level >= PRIME_LEVEL)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (fs_stb) begin
                    if ((u_level != '0) && (d_level != '0)) begin
                        pop = 1'b1;
                    end else begin
                        underrun_evt = 1'b1;
                        state_next   = FILL;
                    end
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u_out        <= '0;
            d_out        <= '0;
            out_valid    <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            out_valid <= pop;
            underrun  <= underrun_evt;
            if (fs_stb) begin
                if (pop) begin
                    u_out <= g_fifo[0].head;
                    d_out <= g_fifo[1].head;
                end else begin
                    u_out <= '0;
                    d_out <= '0;
                end
            end
            if (underrun_evt && (underrun_cnt != {CNT_SIZE{1'b1}})) begin
                underrun_cnt <= underrun_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lms_input_aligner.sv
// Directed bench for lms_input_aligner with default parameters (16-bit samples, DEPTH 4, PRIME 2, 8-bit counter).
module tb_lms_input_aligner;

    localparam int SW = 16;
    localparam int LW = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fs_stb = 1'b0;
    logic          u_valid = 1'b0;
    logic [SW-1:0] u_data = '0;
    logic          u_ready;
    logic          d_valid = 1'b0;
    logic [SW-1:0] d_data = '0;
    logic          d_ready;
    logic [SW-1:0] u_out;
    logic [SW-1:0] d_out;
    logic          out_valid;
    logic          running;
    logic          underrun;
    logic [CW-1:0] underrun_cnt;
    logic [LW-1:0] u_level;
    logic [LW-1:0] d_level;

    int compared = 0;
    int mismatched = 0;
    int exp_cnt;
    logic [SW-1:0] last_u;

    lms_input_aligner #(
        .SAMPLE_SIZE(SW),
        .DEPTH(4),
        .PRIME(2),
        .CNT_SIZE(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fs_stb(fs_stb),
        .u_valid(u_valid),
        .u_data(u_data),
        .u_ready(u_ready),
        .d_valid(d_valid),
        .d_data(d_data),
        .d_ready(d_ready),
        .u_out(u_out),
        .d_out(d_out),
        .out_valid(out_valid),
        .running(running),
        .underrun(underrun),
        .underrun_cnt(underrun_cnt),
        .u_level(u_level),
        .d_level(d_level)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [SW-1:0] u, input logic [SW-1:0] d);
        u_valid = 1'b1; u_data = u;
        d_valid = 1'b1; d_data = d;
        step();
        u_valid = 1'b0;
        d_valid = 1'b0;
    endtask

    task automatic push_d(input logic [SW-1:0] d);
        d_valid = 1'b1; d_data = d;
        step();
        d_valid = 1'b0;
    endtask

    task automatic strobe();
        fs_stb = 1'b1;
        step();
        fs_stb = 1'b0;
    endtask

    initial begin
        // Reset state
        step(); step();
        check("rst_u_out", u_out, 0);
        check("rst_d_out", d_out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_underrun", underrun, 0);
        check("rst_cnt", underrun_cnt, 0);
        check("rst_running", running, 0);
        check("rst_u_level", u_level, 0);
        check("rst_u_ready", u_ready, 1);
        rst = 1'b0;
        step();

        // Strobes while FILL with nothing buffered
        repeat (3) begin
            repeat (7) step();
            strobe();
            check("fill_u_out", u_out, 0);
            check("fill_d_out", d_out, 0);
            check("fill_out_valid", out_valid, 0);
            check("fill_underrun", underrun, 0);
            check("fill_cnt", underrun_cnt, 0);
            check("fill_running", running, 0);
        end

        // Prime and first aligned pairs
        push_pair(16'h0011, 16'h0A0A);
        push_pair(16'h0022, 16'h0B0B);
        check("prime_running_early", running, 0);
        step();
        check("prime_running", running, 1);
        strobe();
        check("p1_u_out", u_out, 16'h0011);
        check("p1_d_out", d_out, 16'h0A0A);
        check("p1_out_valid", out_valid, 1);
        check("p1_u_level", u_level, 1);
        step();
        check("p1_valid_pulse", out_valid, 0);
        check("p1_hold", u_out, 16'h0011);
        strobe();
        check("p2_u_out", u_out, 16'h0022);
        check("p2_d_out", d_out, 16'h0B0B);
        check("p2_out_valid", out_valid, 1);

        // u keeps streaming, d stops after three samples
        push_pair(16'h0101, 16'h0201);
        push_pair(16'h0102, 16'h0202);
        push_pair(16'h0103, 16'h0203);
        for (int k = 0; k < 3; k++) begin
            u_valid = 1'b1;
            u_data = 16'h0104 + 16'(k);
            strobe();
            u_valid = 1'b0;
            check("stream_u_out", u_out, 32'h0101 + k);
            check("stream_d_out", d_out, 32'h0201 + k);
        end
        check("stream_u_level", u_level, 3);
        check("stream_d_level", d_level, 0);
        strobe();
        check("ur_pulse", underrun, 1);
        check("ur_u_out", u_out, 0);
        check("ur_d_out", d_out, 0);
        check("ur_out_valid", out_valid, 0);
        check("ur_cnt", underrun_cnt, 1);
        check("ur_running", running, 0);
        check("ur_u_level", u_level, 3);
        step();
        check("ur_pulse_end", underrun, 0);
        push_d(16'h0204);
        push_d(16'h0205);
        step();
        check("resume_running", running, 1);
        strobe();
        check("resume_u_out", u_out, 16'h0104);
        check("resume_d_out", d_out, 16'h0204);
        strobe();
        check("resume2_u_out", u_out, 16'h0105);
        check("resume2_d_out", d_out, 16'h0205);

        // Full FIFO backpressure
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push_pair(16'h0301 + 16'(k), 16'h0401 + 16'(k));
        end
        check("full_u_ready", u_ready, 0);
        check("full_d_ready", d_ready, 0);
        check("full_u_level", u_level, 4);
        u_valid = 1'b1;
        u_data = 16'h0305;
        step(); step();
        check("full_hold_level", u_level, 4);
        check("full_running", running, 1);
        strobe();
        check("full_pop_u_out", u_out, 16'h0301);
        check("full_pop_ready", u_ready, 1);
        check("full_pop_level", u_level, 3);
        step();
        u_valid = 1'b0;
        check("full_accept_level", u_level, 4);
        for (int k = 0; k < 3; k++) begin
            strobe();
            check("drain_u_out", u_out, 32'h0302 + k);
            check("drain_d_out", d_out, 32'h0402 + k);
        end
        strobe();
        check("drain_underrun", underrun, 1);
        check("drain_cnt", underrun_cnt, 1);
        check("drain_u_level", u_level, 1);

        // Repeated underruns up to counter saturation
        exp_cnt = 1;
        last_u = '0;
        for (int i = 0; i < 300; i++) begin
            push_pair(16'h5000 + 16'(2 * i), 16'h7000 + 16'(2 * i));
            push_pair(16'h5001 + 16'(2 * i), 16'h7001 + 16'(2 * i));
            last_u = 16'h5001 + 16'(2 * i);
            strobe();
            if (i == 0) begin
                check("edge_strobe_out_valid", out_valid, 0);
                check("edge_strobe_u_out", u_out, 0);
                check("edge_strobe_running", running, 1);
                check("edge_strobe_u_level", u_level, 3);
                check("edge_strobe_d_level", d_level, 2);
            end
            strobe();
            strobe();
            strobe();
            if (exp_cnt < 255) exp_cnt++;
            check("sat_underrun", underrun, 1);
            check("sat_cnt", underrun_cnt, exp_cnt);
        end
        check("sat_final", underrun_cnt, 255);

        // Asynchronous reset mid-stream
        push_pair(16'h6100, 16'h6000);
        push_pair(16'h6101, 16'h6001);
        push_d(16'h6002);
        strobe();
        check("pre_rst_u_out", u_out, last_u);
        check("pre_rst_d_out", d_out, 16'h6000);
        push_pair(16'h6102, 16'h6003);
        check("pre_rst_u_level", u_level, 3);
        check("pre_rst_d_level", d_level, 3);
        check("pre_rst_running", running, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_u_level", u_level, 0);
        check("arst_d_level", d_level, 0);
        check("arst_u_out", u_out, 0);
        check("arst_d_out", d_out, 0);
        check("arst_running", running, 0);
        check("arst_cnt", underrun_cnt, 0);
        check("arst_u_ready", u_ready, 1);
        step();
        rst = 1'b0;
        step();
        strobe();
        check("post_rst_u_out", u_out, 0);
        check("post_rst_d_out", d_out, 0);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_underrun", underrun, 0);
        check("post_rst_running", running, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lms_input_aligner.md
Name: lms_input_aligner

Overview:
- Upstream stage of the LMS filter: accepts reference (u) and desired (d) samples from two independent valid/ready producers.
- Buffers each stream in its own small FIFO.
- On every sample-rate strobe, releases one time-aligned (u, d) pair on registered outputs that feed the LMS filter's sample inputs.
- Hides producer jitter, keeps u/d pairing intact, and reports underruns.

Parameters:
- SAMPLE_SIZE, 16, width of u and d samples (two's complement).
- DEPTH, 4, entries per FIFO; power of two, >= 2.
- PRIME, 2, minimum entries required in BOTH FIFOs before RUN is entered; 1 <= PRIME <= DEPTH.
- CNT_SIZE, 8, width of the saturating underrun counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- fs_stb  in  1  one-cycle sample-rate tick (same pulse that drives the LMS filter's sample load)
- u_valid  in  1  u producer has data
- u_data  in  SAMPLE_SIZE  u sample
- u_ready  out  1  u FIFO can accept
- d_valid  in  1  d producer has data
- d_data  in  SAMPLE_SIZE  d sample
- d_ready  out  1  d FIFO can accept
- u_out  out  SAMPLE_SIZE  aligned u sample to filter
- d_out  out  SAMPLE_SIZE  aligned d sample to filter
- out_valid  out  1  one-cycle pulse: u_out/d_out updated with real data
- running  out  1  1 in RUN state
- underrun  out  1  one-cycle pulse on an underrun event
- underrun_cnt  out  CNT_SIZE  saturating underrun count
- u_level  out  clog2(DEPTH)+1  u FIFO occupancy
- d_level  out  clog2(DEPTH)+1  d FIFO occupancy

Behaviour:
- Reset: asynchronous, active-high.
  - Clears both FIFOs (levels 0, pointers 0).
  - u_out, d_out, out_valid, underrun, underrun_cnt = 0; running = 0; state = FILL.
  - Reset mid-operation discards all buffered samples immediately.
- FIFOs: independent, identical.
  - x_ready = (x_level != DEPTH), combinational from the registered level.
  - Push when x_valid && x_ready.
  - Pointers wrap modulo DEPTH; level = 0..DEPTH.
  - Push and pop in the same cycle: level unchanged, both pointers advance.
  - Pop eligibility uses the level at the start of the cycle, so a sample pushed in cycle N cannot be popped before cycle N+1.
  - Full FIFO: ready low; a pop in that cycle raises ready on the next cycle.
- State machine:
  - FILL:
    - On fs_stb: no pop; u_out = d_out = 0 next cycle; out_valid stays 0; no underrun counted.
    - Transition to RUN at the first clock edge where u_level >= PRIME && d_level >= PRIME.
  - RUN:
    - On fs_stb with u_level >= 1 && d_level >= 1: pop both heads. Next cycle u_out/d_out = popped values and out_valid = 1 for exactly one cycle.
    - On fs_stb with either FIFO empty (underrun):
      - Neither FIFO is popped, which preserves pairing.
      - Next cycle: u_out = d_out = 0, out_valid = 0, underrun = 1 for one cycle.
      - underrun_cnt increments, saturating at 2^CNT_SIZE-1.
      - State returns to FILL.
- Latency:
  - fs_stb in cycle N -> outputs and pulses valid in cycle N+1. Outputs hold until the next fs_stb.
  - Write-to-output minimum: pushed in cycle N, appears at the earliest fs_stb in cycle N+1 or later (RUN only).
- fs_stb in the same cycle as the FILL->RUN transition is treated as FILL (zero output, no pop).
- running reflects the registered state.
- Back-to-back fs_stb every cycle is legal: one pop per strobe.

Test Plan:
- Reset, then fs_stb every 8 cycles with no pushes -> u_out=d_out=0, out_valid=0, underrun=0, underrun_cnt=0, running=0.
- Push u=0x0011,0x0022 and d=0x0A0A,0x0B0B, then fs_stb ->
  - running=1 before the strobe.
  - Cycle after strobe: u_out=0x0011, d_out=0x0A0A, out_valid=1.
  - Next strobe gives 0x0022/0x0B0B.
- Stream u continuously and stop d after 3 samples ->
  - 4th RUN strobe: underrun=1 pulse, outputs 0, underrun_cnt=1, state FILL, u_level unchanged.
  - Resuming d re-enters RUN with intact pairing.
- Push 5 u samples with DEPTH=4 and no strobes -> u_ready low after the 4th; 5th held by the producer. A strobe (RUN) pops one; u_ready high the next cycle; 5th accepted.
- Force 300 underruns with CNT_SIZE=8 -> underrun_cnt saturates at 255.
- Assert rst mid-stream with both levels at 3 -> levels 0, outputs 0, running=0 immediately. The first strobe after release outputs zeros.
